blink_mmu: RTL and testbench

// - Parametrised Blink memory/IO mapper placed between the tv80s core and the external ROM/RAM.
// - Maps the 16-bit logical address through NSEG bank registers and COM into a PHYS_W-bit physical address.
// - Decodes ROM/RAM chip selects and holds the bank and COM I/O registers with registered read-back.
// - Inserts per-region wait states through a counter FSM driving wait_n.

---
 rtl/blink_mmu.sv | 207 ++++++++++++++++++++
 tb/tb_blink_mmu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_mmu.sv
// Blink memory/IO mapper: logical-to-physical banking, chip selects, COM/SR I/O registers and wait states.
// Optional ROM write protection is enabled by defining MMU_WRPROT_EN.
module blink_mmu #(
  parameter int               NSEG     = 4,
  parameter int               BANK_W   = 8,
  parameter logic [7:0]       COM_ADDR = 8'hB0,
  parameter logic [7:0]       SR_BASE  = 8'hD0,
  parameter logic [BANK_W-1:0] RAM_BASE = 'h20,
  parameter logic [BANK_W-1:0] RAM_END  = 'h40,
  parameter int               RAMS_BIT = 2,
  parameter int               ROM_WS   = 1,
  parameter int               RAM_WS   = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [15:0]                       cpu_a,
  input  logic [7:0]                        cpu_do,
  input  logic                              cpu_mreq_n,
  input  logic                              cpu_iorq_n,
  input  logic                              cpu_rd_n,
  input  logic                              cpu_wr_n,
  output logic [BANK_W+15-$clog2(NSEG):0]   phys_a,
  output logic                              rom_ce_n,
  output logic                              ram_ce_n,
  output logic                              mem_oe_n,
  output logic                              mem_we_n,
  output logic [7:0]                        io_do,
  output logic                              io_hit,
  output logic [7:0]                        com,
  output logic                              wait_n,
  output logic                              wp_err
);

  // state | meaning
  // IDLE  | no wait sequence; a fresh mreq with ws>0 pulls wait_n low and loads cnt
  // WAIT  | wait_n low; cnt holds the remaining low cycles, leaves at terminal count
  // HOLD  | wait states served; wait_n high until mreq_n releases
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  localparam int KW = $clog2(NSEG);
  localparam int W  = 16 - KW;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mreq_q;
  logic [7:0]        com_q, com_d;
  logic [BANK_W-1:0] sr_q [NSEG];
  logic [BANK_W-1:0] sr_d [NSEG];
  logic [7:0]        io_do_q, io_do_d;
  logic              io_hit_q, io_hit_d;

  logic [KW-1:0]     win;
  logic [BANK_W-1:0] bank;
  logic              rom_sel, ram_sel;
  logic              mem_rd, mem_wr, wp_block;
  logic              io_rd, io_wr, com_hit, sr_hit;
  logic [7:0]        io_off;
  logic [KW-1:0]     sr_idx;
  logic [3:0]        ws;
  logic              start;

  // The bottom half of window 0 is either fixed ROM bank 0 or the first RAM bank.
  always_comb begin
    win = cpu_a[15:W];
    if (win != '0)
      bank = sr_q[win];
    else if (cpu_a[W-1])
      bank = sr_q[0];
    else
      bank = com_q[RAMS_BIT] ? RAM_BASE : '0;
  end

  assign phys_a  = {bank, cpu_a[W-1:0]};
  assign rom_sel = bank < RAM_BASE;
  assign ram_sel = !rom_sel && (bank < RAM_END);

  assign mem_rd = ~cpu_mreq_n & ~cpu_rd_n;
  assign mem_wr = ~cpu_mreq_n & ~cpu_wr_n;

  assign rom_ce_n = ~(~cpu_mreq_n & rom_sel) | wp_block;
  assign ram_ce_n = ~(~cpu_mreq_n & ram_sel);
  assign mem_oe_n = ~mem_rd;
  assign mem_we_n = ~mem_wr | wp_block;

  assign io_rd   = ~cpu_iorq_n & ~cpu_rd_n;
  assign io_wr   = ~cpu_iorq_n & ~cpu_wr_n;
  assign com_hit = cpu_a[7:0] == COM_ADDR;
  assign io_off  = cpu_a[7:0] - SR_BASE;
  assign sr_hit  = io_off < 8'(NSEG);
  assign sr_idx  = io_off[KW-1:0];

  always_comb begin
    com_d    = com_q;
    sr_d     = sr_q;
    io_do_d  = io_do_q;
    io_hit_d = io_hit_q;
    if (io_wr) begin
      if (com_hit) com_d = cpu_do;
      if (sr_hit)  sr_d[sr_idx] = cpu_do;
    end
    if (io_rd) begin
      if (com_hit) begin
        io_do_d  = com_q;
        io_hit_d = 1'b1;
      end else if (sr_hit) begin
        io_do_d  = sr_q[sr_idx];
        io_hit_d = 1'b1;
      end else begin
        io_do_d  = 8'hFF;
        io_hit_d = 1'b0;
      end
    end else if (cpu_iorq_n) begin
      io_hit_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      com_q    <= '0;
      sr_q     <= '{default: '0};
      io_do_q  <= 8'hFF;
      io_hit_q <= 1'b0;
    end else begin
      com_q    <= com_d;
      sr_q     <= sr_d;
      io_do_q  <= io_do_d;
      io_hit_q <= io_hit_d;
    end
  end

  assign io_do  = io_do_q;
  assign io_hit = io_hit_q;
  assign com    = com_q;

`ifdef MMU_WRPROT_EN
  logic wp_err_q, wp_err_d;

  assign wp_block = mem_wr & rom_sel;

  always_comb begin
    wp_err_d = wp_err_q;
    if (io_wr && com_hit) wp_err_d = 1'b0;
    if (wp_block)         wp_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) wp_err_q <= 1'b0;
    else          wp_err_q <= wp_err_d;
  end

  assign wp_err = wp_err_q;
`else
  assign wp_block = 1'b0;
  assign wp_err   = 1'b0;
`endif

  assign ws    = rom_sel ? 4'(ROM_WS) : (ram_sel ? 4'(RAM_WS) : 4'd0);
  assign start = ~cpu_mreq_n & mreq_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mreq_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mreq_q  <= cpu_mreq_n;
    end
  end

  // The start cycle is the first low cycle, so WAIT covers the remaining ws-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && ws != 4'd0) begin
          cnt_d   = ws - 4'd1;
          state_d = (ws == 4'd1) ? S_HOLD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cpu_mreq_n) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_d == 4'd0) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cpu_mreq_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wait_n = 1'b1;
    case (state_q)
      S_IDLE:  if (start && ws != 4'd0) wait_n = 1'b0;
      S_WAIT:  wait_n = cpu_mreq_n;
      default: wait_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_blink_mmu.sv
// Randomised scoreboard bench for blink_mmu against a cycle-level behavioural model of the mapper.
module tb_blink_mmu;

  localparam int          NSEG     = 4;
  localparam int          BANK_W   = 8;
  localparam int          W        = 14;
  localparam int          PHYS_W   = BANK_W + W;
  localparam logic [7:0]  COM_ADDR = 8'hB0;
  localparam logic [7:0]  SR_BASE  = 8'hD0;
  localparam int          RAM_BASE = 'h20;
  localparam int          RAM_END  = 'h40;
  localparam int          RAMS_BIT = 2;
  localparam int          ROM_WS   = 3;
  localparam int          RAM_WS   = 1;
`ifdef MMU_WRPROT_EN
  localparam bit          WP       = 1'b1;
`else
  localparam bit          WP       = 1'b0;
`endif

  logic              clk;
  logic              reset_n;
  logic [15:0]       cpu_a;
  logic [7:0]        cpu_do;
  logic              cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n;
  logic [PHYS_W-1:0] phys_a;
  logic              rom_ce_n, ram_ce_n, mem_oe_n, mem_we_n;
  logic [7:0]        io_do;
  logic              io_hit;
  logic [7:0]        com;
  logic              wait_n;
  logic              wp_err;

  blink_mmu #(
    .NSEG(NSEG), .BANK_W(BANK_W), .COM_ADDR(COM_ADDR), .SR_BASE(SR_BASE),
    .RAM_BASE(8'h20), .RAM_END(8'h40), .RAMS_BIT(RAMS_BIT),
    .ROM_WS(ROM_WS), .RAM_WS(RAM_WS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_do(cpu_do),
    .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .phys_a(phys_a), .rom_ce_n(rom_ce_n), .ram_ce_n(ram_ce_n), .mem_oe_n(mem_oe_n),
    .mem_we_n(mem_we_n), .io_do(io_do), .io_hit(io_hit), .com(com), .wait_n(wait_n),
    .wp_err(wp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] phys;
    logic        rom_ce_n, ram_ce_n, oe_n, we_n, wait_n, io_hit, wp_err;
    logic [7:0]  io_do, com;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state
  logic [7:0] m_com;
  logic [7:0] m_sr [NSEG];
  logic [7:0] m_io_do;
  logic       m_io_hit, m_wp, m_mreq_prev;
  int         run, ws_cur;

  function automatic int cur_bank(input logic [15:0] a);
    int k;
    k = int'(a) / (1 << W);
    if (k != 0)                   return int'(m_sr[k]);
    if (((a >> (W - 1)) & 1) != 0) return int'(m_sr[0]);
    return m_com[RAMS_BIT] ? RAM_BASE : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int b, p;
    b = cur_bank(cpu_a);
    p = int'(cpu_a[7:0]);
    if (!reset_n) begin
      m_com = 8'h00;
      for (int i = 0; i < NSEG; i++) m_sr[i] = 8'h00;
      m_io_do = 8'hFF; m_io_hit = 1'b0; m_wp = 1'b0;
      m_mreq_prev = 1'b1; run = 0; ws_cur = 0;
    end else begin
      if (!cpu_iorq_n && !cpu_wr_n) begin
        if (p == int'(COM_ADDR)) begin m_com = cpu_do; m_wp = 1'b0; end
        if (p >= int'(SR_BASE) && p < int'(SR_BASE) + NSEG) m_sr[p - int'(SR_BASE)] = cpu_do;
      end
      if (!cpu_iorq_n && !cpu_rd_n) begin
        if (p == int'(COM_ADDR)) begin m_io_do = m_com; m_io_hit = 1'b1; end
        else if (p >= int'(SR_BASE) && p < int'(SR_BASE) + NSEG) begin
          m_io_do = m_sr[p - int'(SR_BASE)]; m_io_hit = 1'b1;
        end else begin m_io_do = 8'hFF; m_io_hit = 1'b0; end
      end else if (cpu_iorq_n) begin
        m_io_hit = 1'b0;
      end
      if (WP && !cpu_mreq_n && !cpu_wr_n && b < RAM_BASE) m_wp = 1'b1;
      if (!cpu_mreq_n) run++;
      m_mreq_prev = cpu_mreq_n;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    int   b;
    bit   rom, ram, memw, wpb;
    b    = cur_bank(cpu_a);
    rom  = b < RAM_BASE;
    ram  = !rom && b < RAM_END;
    memw = !cpu_mreq_n && !cpu_wr_n;
    wpb  = WP && memw && rom;
    if (!cpu_mreq_n && m_mreq_prev) begin
      run = 0;
      ws_cur = rom ? ROM_WS : (ram ? RAM_WS : 0);
    end
    e.phys     = 32'(b * (1 << W) + (int'(cpu_a) % (1 << W)));
    e.rom_ce_n = !(!cpu_mreq_n && rom) || wpb;
    e.ram_ce_n = !(!cpu_mreq_n && ram);
    e.oe_n     = !(!cpu_mreq_n && !cpu_rd_n);
    e.we_n     = !memw || wpb;
    e.wait_n   = !(!cpu_mreq_n && run < ws_cur);
    e.io_do    = m_io_do;
    e.io_hit   = m_io_hit;
    e.com      = m_com;
    e.wp_err   = m_wp;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic rst_n, input logic mreq_n, input logic iorq_n,
                     input logic rd_n, input logic wr_n, input logic [15:0] a, input logic [7:0] d);
    @(posedge clk);
    model_edge();
    #1;
    reset_n = rst_n; cpu_mreq_n = mreq_n; cpu_iorq_n = iorq_n;
    cpu_rd_n = rd_n; cpu_wr_n = wr_n; cpu_a = a; cpu_do = d;
    push_expected();
  endtask

  task automatic idle();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'($urandom), 8'($urandom));
  endtask

  task automatic mem(input logic [15:0] a, input bit wr, input int len);
    for (int i = 0; i < len; i++)
      cyc(1'b1, 1'b0, 1'b1, wr, !wr, a, 8'($urandom));
    idle();
  endtask

  task automatic io(input logic [7:0] port, input bit wr, input logic [7:0] d);
    logic [15:0] a;
    a = {8'($urandom), port};
    for (int i = 0; i < 2; i++)
      cyc(1'b1, 1'b1, 1'b0, wr, !wr, a, d);
    idle();
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("phys_a",   32'(phys_a),   e.phys);
      chk("rom_ce_n", 32'(rom_ce_n), 32'(e.rom_ce_n));
      chk("ram_ce_n", 32'(ram_ce_n), 32'(e.ram_ce_n));
      chk("mem_oe_n", 32'(mem_oe_n), 32'(e.oe_n));
      chk("mem_we_n", 32'(mem_we_n), 32'(e.we_n));
      chk("wait_n",   32'(wait_n),   32'(e.wait_n));
      chk("io_do",    32'(io_do),    32'(e.io_do));
      chk("io_hit",   32'(io_hit),   32'(e.io_hit));
      chk("com",      32'(com),      32'(e.com));
      chk("wp_err",   32'(wp_err),   32'(e.wp_err));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] port, d;
    reset_n = 1'b0; cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1;
    cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_a = 16'h0000; cpu_do = 8'h00;

    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);

    mem(16'h0000, 1'b0, 3);
    io(8'hD2, 1'b1, 8'h21);
    mem(16'h8123, 1'b0, 3);
    io(8'hD2, 1'b0, 8'h00);
    io(8'hB0, 1'b1, 8'h04);
    mem(16'h0010, 1'b0, 3);
    mem(16'h2010, 1'b0, 6);
    mem(16'h2010, 1'b0, 1);
    mem(16'h2010, 1'b0, 2);
    io(8'hD3, 1'b1, 8'h7F);
    mem(16'hC000, 1'b0, 3);
    io(8'h55, 1'b0, 8'h00);
    io(8'hB0, 1'b0, 8'h00);
    io(8'hB0, 1'b1, 8'h00);
    mem(16'h0100, 1'b1, 3);
    io(8'hB0, 1'b1, 8'h00);

    // Reset landing in the middle of a ROM wait sequence
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 8'h00);
    idle();
    mem(16'h0000, 1'b0, 2);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: mem(16'($urandom), 1'b0, $urandom_range(1, 6));
        4, 5:       mem(16'($urandom), 1'b1, $urandom_range(1, 4));
        default: begin
          case ($urandom_range(0, 3))
            0:       port = COM_ADDR;
            1:       port = SR_BASE + 8'($urandom_range(0, NSEG - 1));
            2:       port = SR_BASE + 8'($urandom_range(NSEG, 7));
            default: port = 8'($urandom);
          endcase
          case ($urandom_range(0, 2))
            0:       d = 8'($urandom_range(0, 8'h1F));
            1:       d = 8'($urandom_range(8'h20, 8'h3F));
            default: d = 8'($urandom);
          endcase
          io(port, ($urandom_range(0, 1) == 0), d);
        end
      endcase
    end

    idle();
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
